// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs, states and mux selects.
// Imported by multicycle_ctrl and mc_alu_decoder.
package multicycle_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // NONE keeps alu_control at 000 in states that do not use the ALU.
    localparam logic [1:0] ALUOP_NONE  = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode: fixed add/sub from the FSM, or R-type funct decode.
module mc_alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = 3'b000;
        unique case (aluop_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alu_control_o = ALU_ADD;
                    FUNCT_SUB: alu_control_o = ALU_SUB;
                    FUNCT_AND: alu_control_o = ALU_AND;
                    FUNCT_OR:  alu_control_o = ALU_OR;
                    FUNCT_SLT: alu_control_o = ALU_SLT;
                    default:   alu_control_o = 3'b000;
                endcase
            end
            default: alu_control_o = 3'b000;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM driving all datapath selects and write enables.
// MULTICYCLE_MEM_HANDSHAKE_EN adds mem_ready/mem_req and stalls memory states until ready.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    input  logic               mem_ready,
    output logic               mem_req,
`endif
    output logic               pc_en,
    output logic               iord,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         pc_src,
    output logic [2:0]         alu_control,
    output logic               illegal_op,
    output logic               instr_done,
    output logic [STATE_W-1:0] state_o
);

    state_e     state_q, state_d, dec_state;
    logic       pc_write, branch, mem_rdy;
    logic [1:0] aluop;

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    assign mem_rdy = mem_ready;
    assign mem_req = (dec_state == S_FETCH) || (dec_state == S_MEMRD) || (dec_state == S_MEMWR);
`else
    assign mem_rdy = 1'b1;
`endif

    // During reset the outputs decode as FETCH; write enables are masked below.
    assign dec_state = rst ? S_FETCH : state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        pc_src     = PCSRC_ALU;
        aluop      = ALUOP_NONE;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        case (dec_state)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                aluop     = ALUOP_ADD;
                ir_write  = mem_rdy;
                pc_write  = mem_rdy;
                state_d   = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                aluop     = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d    = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_ADD;
                state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_rdy;
                state_d    = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                aluop      = ALUOP_SUB;
                pc_src     = PCSRC_ALUOUT;
                branch     = 1'b1;
                instr_done = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluop     = ALUOP_ADD;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            pc_write  = 1'b0;
            branch    = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

    assign pc_en   = pc_write | (branch & zero);
    assign state_o = STATE_W'(state_q);

    mc_alu_decoder u_alu_dec (
        .aluop_i       (aluop),
        .funct_i       (funct),
        .alu_control_o (alu_control)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised self-checking bench for multicycle_ctrl against a per-instruction reference model.
module tb_multicycle_ctrl;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    typedef struct packed {
        logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b, pc_src;
        logic [2:0] alu_control;
        logic       illegal_op, instr_done;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst, zero;
    logic [5:0] op, funct;
    logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic       illegal_op, instr_done;
    logic [3:0] state_o;
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    logic       mem_ready, mem_req;
`endif
    outs_t      act;
    int         tests = 0;
    int         fails = 0;

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
`endif
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .illegal_op  (illegal_op),
        .instr_done  (instr_done),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    assign act = {pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                  alu_src_b, pc_src, alu_control, illegal_op, instr_done};

    function automatic bit is_legal(input logic [5:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) || (o == ADDI) || (o == JMP);
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    // Nominal state walk of one instruction, as listed per opcode.
    function automatic int state_at(input logic [5:0] o, input int idx);
        int s[5];
        s = '{0, 1, 0, 0, 0};
        case (o)
            LW:      s = '{0, 1, 2, 3, 4};
            SW:      s = '{0, 1, 2, 5, 0};
            RT:      s = '{0, 1, 6, 7, 0};
            ADDI:    s = '{0, 1, 9, 10, 0};
            BEQ:     s = '{0, 1, 8, 0, 0};
            JMP:     s = '{0, 1, 11, 0, 0};
            default: s = '{0, 1, 0, 0, 0};
        endcase
        return s[idx];
    endfunction

    function automatic int cpi(input logic [5:0] o);
        case (o)
            LW:              return 5;
            SW, RT, ADDI:    return 4;
            BEQ, JMP:        return 3;
            default:         return 2;
        endcase
    endfunction

    function automatic outs_t exp_out(input int st, input logic [5:0] o, input logic [5:0] f,
                                      input logic z, input logic rdy);
        outs_t e;
        e = '0;
        case (st)
            0:  begin e.alu_src_b = 2'b01; e.alu_control = 3'b010;
                      e.ir_write = rdy; e.pc_en = rdy; end
            1:  begin e.alu_src_b = 2'b11; e.alu_control = 3'b010; e.illegal_op = !is_legal(o); end
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
            3:  e.iord = 1;
            4:  begin e.mem_to_reg = 1; e.reg_write = 1; e.instr_done = 1; end
            5:  begin e.iord = 1; e.mem_write = 1; e.instr_done = rdy; end
            6:  begin e.alu_src_a = 1; e.alu_control = funct_alu(f); end
            7:  begin e.reg_dst = 1; e.reg_write = 1; e.instr_done = 1; end
            8:  begin e.alu_src_a = 1; e.alu_control = 3'b110; e.pc_src = 2'b01;
                      e.pc_en = z; e.instr_done = 1; end
            9:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_control = 3'b010; end
            10: begin e.reg_write = 1; e.instr_done = 1; end
            11: begin e.pc_src = 2'b10; e.pc_en = 1; e.instr_done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // zmode: 0 random zero, 1 zero forced high, 2 zero forced low.
    task automatic run_instr(input logic [5:0] iop, input logic [5:0] ifn, input int zmode,
                             input bit hs_random);
        int         n, idx, waits, done_cnt, rw_cnt, st, exp_rw;
        logic       z, rdy;
        outs_t      e;
        n = cpi(iop); idx = 0; waits = 0; done_cnt = 0; rw_cnt = 0;
        op = iop; funct = ifn;
        while (idx < n) begin
            st = state_at(iop, idx);
            z = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            rdy = 1'b1;
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
            if (hs_random && (st == 0 || st == 3 || st == 5) && waits < 4)
                rdy = 1'($urandom_range(0, 1));
            mem_ready = rdy;
`else
            if (hs_random) rdy = 1'b1;
`endif
            zero = z;
            @(negedge clk);
            tests++;
            if (state_o !== 4'(st)) begin
                fails++;
                $display("FAIL state op=%b idx=%0d: got %0d want %0d", iop, idx, state_o, st);
            end
            e = exp_out(st, iop, ifn, z, rdy);
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL outputs op=%b st=%0d: got %h want %h", iop, st, act, e);
            end
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
            tests++;
            if (mem_req !== (st == 0 || st == 3 || st == 5)) begin
                fails++;
                $display("FAIL mem_req st=%0d: got %b", st, mem_req);
            end
`endif
            if (instr_done === 1'b1) done_cnt++;
            if (reg_write === 1'b1) rw_cnt++;
            @(posedge clk); #1;
            if (rdy) begin idx++; waits = 0; end else waits++;
        end
        tests++;
        if (done_cnt != (is_legal(iop) ? 1 : 0)) begin
            fails++;
            $display("FAIL instr_done_count op=%b: got %0d", iop, done_cnt);
        end
        exp_rw = (iop == LW || iop == RT || iop == ADDI) ? 1 : 0;
        tests++;
        if (rw_cnt != exp_rw) begin
            fails++;
            $display("FAIL reg_write_count op=%b: got %0d want %0d", iop, rw_cnt, exp_rw);
        end
    endtask

    task automatic test_reset();
        outs_t e;
        rst = 1'b1; op = LW; funct = 6'b101010; zero = 1'b1;
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
        mem_ready = 1'b1;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        e = exp_out(0, op, funct, 1'b1, 1'b1);
        e.pc_en = 0; e.ir_write = 0;
        tests++;
        if (state_o !== 4'd0) begin
            fails++; $display("FAIL reset_state: got %0d want 0", state_o);
        end
        tests++;
        if (act !== e) begin
            fails++; $display("FAIL reset_outputs: got %h want %h", act, e);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(LW, 6'($urandom), 0, 1'b0);
    endtask

    task automatic test_rtype_slt();
        run_instr(RT, 6'b101010, 0, 1'b0);
    endtask

    task automatic test_beq();
        run_instr(BEQ, 6'($urandom), 1, 1'b0);
        run_instr(BEQ, 6'($urandom), 2, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'b100000, 0, 1'b0);
    endtask

    task automatic test_sw_reset();
        op = SW; funct = 6'($urandom); zero = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        tests++;
        if (state_o !== 4'd5) begin
            fails++; $display("FAIL sw_reach_memwr: got %0d want 5", state_o);
        end
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_write !== 1'b0 || instr_done !== 1'b0) begin
            fails++;
            $display("FAIL sw_reset_mem_write: got mw=%b done=%b want 0 0", mem_write, instr_done);
        end
        @(posedge clk); #1;
        tests++;
        if (state_o !== 4'd0) begin
            fails++; $display("FAIL sw_reset_state: got %0d want 0", state_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        logic [5:0] fns[5];
        logic [5:0] o, f;
        ops = '{LW, SW, RT, BEQ, ADDI, JMP, 6'b000000};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < 80; i++) begin
            o = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 6) == 0) begin
                o = 6'($urandom);
            end
            f = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(o, f, 0, 1'b1);
        end
    endtask

`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
    task automatic test_handshake();
        op = 6'b111111; funct = 6'd0; zero = 1'b0;
        mem_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (state_o !== 4'd0 || ir_write !== 1'b0 || pc_en !== 1'b0 || mem_req !== 1'b1) begin
                fails++;
                $display("FAIL hs_wait: got st=%0d irw=%b pcen=%b req=%b want 0 0 0 1",
                         state_o, ir_write, pc_en, mem_req);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (ir_write !== 1'b1 || pc_en !== 1'b1) begin
            fails++; $display("FAIL hs_ready: got irw=%b pcen=%b want 1 1", ir_write, pc_en);
        end
        @(posedge clk); #1;
        tests++;
        if (state_o !== 4'd1) begin
            fails++; $display("FAIL hs_decode: got %0d want 1", state_o);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_lw();
        test_rtype_slt();
        test_beq();
        test_illegal();
        test_sw_reset();
`ifdef MULTICYCLE_MEM_HANDSHAKE_EN
        test_handshake();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
